// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port among 2^PORT_BITS cache-style requesters.
// Define MEM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins priority instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int PORT_BITS  = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [(1<<PORT_BITS)*ADDR_WIDTH-1:0]    addr,
    input  logic [(1<<PORT_BITS)*WORD_WIDTH-1:0]    din,
    output logic [(1<<PORT_BITS)*WORD_WIDTH-1:0]    dout,
    input  logic [(1<<PORT_BITS)-1:0]               re,
    input  logic [(1<<PORT_BITS)-1:0]               we,
    output logic [(1<<PORT_BITS)-1:0]               ready,
    output logic [ADDR_WIDTH-1:0]                   maddr,
    output logic [WORD_WIDTH-1:0]                   mout,
    input  logic [WORD_WIDTH-1:0]                   min,
    output logic                                    mre,
    output logic                                    mwe,
    input  logic                                    mready
);
    localparam int PORTS = 1 << PORT_BITS;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr_q [PORTS];
    logic [WORD_WIDTH-1:0]  din_q  [PORTS];
    logic [WORD_WIDTH-1:0]  dout_q [PORTS];
    logic [PORTS-1:0]       read_q;
    logic [PORTS-1:0]       pending;
    logic [PORT_BITS-1:0]   cur;
    logic [PORT_BITS-1:0]   grant;
    logic                   grant_valid;
    logic                   start;
    logic                   complete;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
    logic [PORT_BITS-1:0]   last_grant;
    logic [PORT_BITS-1:0]   rr_idx;
`endif

    for (genvar i = 0; i < PORTS; i++) begin : g_dout
        assign dout[i*WORD_WIDTH +: WORD_WIDTH] = dout_q[i];
    end

    // Descending scan so the lowest search offset is the final (winning) assignment.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                grant       = PORT_BITS'(k);
                grant_valid = 1'b1;
            end
        end
`else
        rr_idx = '0;
        for (int k = PORTS; k >= 1; k--) begin
            rr_idx = last_grant + PORT_BITS'(k);
            if (pending[rr_idx]) begin
                grant       = rr_idx;
                grant_valid = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion waits for the strobe to drop so each strobe lasts exactly one cycle.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && mready) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!mre && !mwe && mready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request payload only matters while pending is set, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (ready[i] && (re[i] || we[i])) begin
                addr_q[i] <= addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                din_q[i]  <= din[i*WORD_WIDTH +: WORD_WIDTH];
                read_q[i] <= re[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= '1;
            pending <= '0;
            maddr   <= '0;
            mout    <= '0;
            mre     <= 1'b0;
            mwe     <= 1'b0;
            cur     <= '0;
            for (int i = 0; i < PORTS; i++) begin
                dout_q[i] <= '0;
            end
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
            last_grant <= '1;
`endif
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (ready[i] && (re[i] || we[i])) begin
                    pending[i] <= 1'b1;
                    ready[i]   <= 1'b0;
                end
            end
            if (start) begin
                maddr <= addr_q[grant];
                mout  <= din_q[grant];
                mre   <= read_q[grant];
                mwe   <= !read_q[grant];
                cur   <= grant;
            end else begin
                mre <= 1'b0;
                mwe <= 1'b0;
            end
            if (complete) begin
                if (read_q[cur]) begin
                    dout_q[cur] <= min;
                end
                ready[cur]   <= 1'b1;
                pending[cur] <= 1'b0;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
                last_grant   <= cur;
`endif
            end
        end
    end
endmodule
